// File: rtl/execute.sv
// Execute stage of the in-order RV32I pipeline.
// Takes the registered decode bundle, computes the ALU/branch result and drives the
// register-file writeback port back into decode.
// Ports:
//   req, reset            clock (rising edge), asynchronous active-low reset
//   valid_in .. imm_value_in   decode bundle (pc, opcode, funct3/7, rd, operands, immediate)
//   rs_read               stall to decode, high while an iterative shift is in progress
//   valid_out             one-cycle pulse per completed instruction
//   rd_out, rd_write_out, rd_value_out   writeback (rd_value_out is the address for ld/st)
//   branch_taken_out, branch_target_out  redirect request, qualified by valid_out
module execute #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            req,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [6:0]      alu_op_in,
  input  logic [2:0]      funct3_in,
  input  logic [6:0]      funct7_in,
  input  logic [4:0]      rd_in,
  input  logic            rd_write_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  input  logic [XLEN-1:0] imm_value_in,
  output logic            rs_read,
  output logic            valid_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic [XLEN-1:0] rd_value_out,
  output logic            branch_taken_out,
  output logic [XLEN-1:0] branch_target_out
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [XLEN-1:0]    shreg_q;
  logic               shleft_q, sharith_q;
  logic [4:0]         sh_rd_q;
  logic               sh_wr_q;

  logic [XLEN-1:0]    op_b, res, target, sum_pc_imm, shift_next;
  logic [SHAMT_W-1:0] shamt;
  logic               is_alu, is_shift, shift_start, wr, taken;
  logic               eq, lt, ltu;
  logic               unused_funct7;

  assign unused_funct7 = ^{funct7_in[6], funct7_in[4:0]};

  assign rs_read = (state_q == StShift);

  always_comb begin
    op_b        = (alu_op_in == OpImm) ? imm_value_in : rs2_value_in;
    shamt       = op_b[SHAMT_W-1:0];
    is_alu      = (alu_op_in == OpReg) || (alu_op_in == OpImm);
    is_shift    = is_alu && (funct3_in[1:0] == 2'b01);
    shift_start = is_shift && (shamt != '0);
    eq          = (rs1_value_in == op_b);
    lt          = ($signed(rs1_value_in) < $signed(op_b));
    ltu         = (rs1_value_in < op_b);
    sum_pc_imm  = pc_in + imm_value_in;
    res         = '0;
    wr          = 1'b0;
    taken       = 1'b0;
    target      = '0;
    case (alu_op_in)
      OpReg, OpImm: begin
        wr = rd_write_in;
        case (funct3_in)
          3'b000: res = (alu_op_in == OpReg && funct7_in[5]) ? rs1_value_in - op_b
                                                              : rs1_value_in + op_b;
          3'b010: res = {{(XLEN-1){1'b0}}, lt};
          3'b011: res = {{(XLEN-1){1'b0}}, ltu};
          3'b100: res = rs1_value_in ^ op_b;
          3'b110: res = rs1_value_in | op_b;
          3'b111: res = rs1_value_in & op_b;
          // Shifts reach here only with shamt=0; nonzero amounts go through StShift.
          default: res = rs1_value_in;
        endcase
      end
      OpLui: begin
        wr  = rd_write_in;
        res = imm_value_in;
      end
      OpJal: begin
        wr     = rd_write_in;
        res    = pc_in + XLEN'(4);
        taken  = 1'b1;
        target = sum_pc_imm;
      end
      OpBranch: begin
        // Branches compare rs1 against rs2 (op_b is rs2 for this opcode).
        target = sum_pc_imm;
        case (funct3_in)
          3'b000:  taken = eq;
          3'b001:  taken = !eq;
          3'b100:  taken = lt;
          3'b101:  taken = !lt;
          3'b110:  taken = ltu;
          3'b111:  taken = !ltu;
          default: taken = 1'b0;
        endcase
      end
      OpLoad: begin
        wr  = rd_write_in;
        res = rs1_value_in + imm_value_in;
      end
      OpStore: res = rs1_value_in + imm_value_in;
      default: ;
    endcase
    shift_next = shleft_q ? {shreg_q[XLEN-2:0], 1'b0}
                          : {sharith_q & shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
  end

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      shreg_q           <= '0;
      shleft_q          <= 1'b0;
      sharith_q         <= 1'b0;
      sh_rd_q           <= '0;
      sh_wr_q           <= 1'b0;
      valid_out         <= 1'b0;
      rd_out            <= '0;
      rd_write_out      <= 1'b0;
      rd_value_out      <= '0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
    end else begin
      valid_out    <= 1'b0;
      rd_write_out <= 1'b0;
      case (state_q)
        StIdle: begin
          if (valid_in) begin
            if (shift_start) begin
              state_q   <= StShift;
              cnt_q     <= shamt;
              shreg_q   <= rs1_value_in;
              shleft_q  <= !funct3_in[2];
              sharith_q <= funct7_in[5];
              sh_rd_q   <= rd_in;
              sh_wr_q   <= rd_write_in && (rd_in != 5'd0);
            end else begin
              valid_out         <= 1'b1;
              rd_out            <= rd_in;
              rd_write_out      <= wr && (rd_in != 5'd0);
              rd_value_out      <= res;
              branch_taken_out  <= taken;
              branch_target_out <= target;
            end
          end
        end
        StShift: begin
          if (cnt_q == SHAMT_W'(1)) begin
            state_q           <= StIdle;
            cnt_q             <= '0;
            valid_out         <= 1'b1;
            rd_out            <= sh_rd_q;
            rd_write_out      <= sh_wr_q;
            rd_value_out      <= shift_next;
            branch_taken_out  <= 1'b0;
            branch_target_out <= '0;
          end else begin
            cnt_q   <= cnt_q - SHAMT_W'(1);
            shreg_q <= shift_next;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
